// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_t        : coarse FSM state, encoding visible on the state output
//   instr_class_t  : instruction class latched when leaving ID
//   OP_*/FN_*      : opcode and R-type funct encodings
//   ALU_*          : alu_control codes driven to the datapath ALU
package mips_mc_pkg;

  typedef enum logic [2:0] {
    S_IF = 3'd0,
    S_ID = 3'd1,
    S_EX = 3'd2,
    S_MA = 3'd3,
    S_WB = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ADDI,
    CLS_J
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Unsupported opcodes map to CLS_NOP, which doubles as the illegal marker.
  function automatic instr_class_t decode_class(input logic [5:0] op);
    case (op)
      OP_RTYPE: return CLS_RTYPE;
      OP_LW:    return CLS_LW;
      OP_SW:    return CLS_SW;
      OP_BEQ:   return CLS_BEQ;
      OP_ADDI:  return CLS_ADDI;
      OP_J:     return CLS_J;
      default:  return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master : control unit (consumes IR fields and zero flag, drives all controls)
//   slave  : datapath side (drives IR fields and zero flag, consumes controls)
interface mips_mc_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic [2:0]       state;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_control;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output state, pc_en, pc_src, iord, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_control, illegal_op, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  state, pc_en, pc_src, iord, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_control, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU control decode for the multi-cycle control unit.
//   cls_i           : latched instruction class
//   funct_i         : IR[5:0]
//   state_i         : current FSM state
//   alu_control_o   : ALU operation code
//   funct_illegal_o : funct is not one of the supported R-type operations
// Only EX of R-type and BEQ uses anything other than add.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  instr_class_t cls_i,
  input  logic [5:0]   funct_i,
  input  state_t       state_i,
  output logic [2:0]   alu_control_o,
  output logic         funct_illegal_o
);
  logic [2:0] fn_ctrl;

  always_comb begin
    fn_ctrl         = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_illegal_o = 1'b1;
    endcase

    alu_control_o = ALU_ADD;
    if (state_i == S_EX) begin
      if (cls_i == CLS_RTYPE)    alu_control_o = fn_ctrl;
      else if (cls_i == CLS_BEQ) alu_control_o = ALU_SUB;
    end
  end
endmodule

// File: rtl/mips_mc_control_unit.sv
// Multi-cycle MIPS control unit: walks each instruction through IF/ID/EX/MA/WB
// and drives the datapath enables/selects; counts retired instructions.
//   clk   : system clock
//   reset : synchronous, active-high; outputs held inactive while asserted
//   bus   : master side of mips_mc_control_unit_if (IR fields/zero in, controls out)
//
// state | meaning
// IF    | fetch: IR <= mem[PC], PC <= PC+4
// ID    | decode: branch target into ALUOut, legality check
// EX    | execute / address calc / branch / jump
// MA    | memory access (lw read, sw write)
// WB    | register write-back
module mips_mc_control_unit
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    reset,
  mips_mc_control_unit_if.master bus
);
  state_t           state_q, state_d;
  instr_class_t     cls_q, cls_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  instr_class_t     id_cls;
  logic             id_illegal;
  logic             funct_illegal;
  logic [2:0]       alu_ctrl;

  mips_alu_decoder u_alu_dec (
    .cls_i           (cls_q),
    .funct_i         (bus.funct),
    .state_i         (state_q),
    .alu_control_o   (alu_ctrl),
    .funct_illegal_o (funct_illegal)
  );

  assign id_cls     = decode_class(bus.opcode);
  assign id_illegal = (id_cls == CLS_NOP) || ((id_cls == CLS_RTYPE) && funct_illegal);

  always_comb begin
    state_d = S_IF;
    cls_d   = cls_q;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (id_illegal) begin
          cls_d = CLS_NOP;
        end else begin
          state_d = S_EX;
          cls_d   = id_cls;
        end
      end
      S_EX: begin
        case (cls_q)
          CLS_LW, CLS_SW:     state_d = S_MA;
          CLS_RTYPE, CLS_ADDI: state_d = S_WB;
          CLS_BEQ, CLS_J:     retire  = 1'b1;
          default:            ;
        endcase
      end
      S_MA: begin
        if (cls_q == CLS_LW)      state_d = S_WB;
        else if (cls_q == CLS_SW) retire  = 1'b1;
      end
      S_WB:    retire = 1'b1;
      default: ;
    endcase
    count_d = count_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      cls_q   <= CLS_NOP;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      count_q <= count_d;
    end
  end

  // Moore decode of state+class; only pc_en in BEQ EX looks at zero directly.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.pc_src      = 2'd0;
    bus.iord        = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'd0;
    bus.alu_control = 3'b000;
    bus.illegal_op  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          bus.ir_write    = 1'b1;
          bus.alu_src_b   = 2'd1;
          bus.pc_en       = 1'b1;
          bus.alu_control = alu_ctrl;
        end
        S_ID: begin
          bus.alu_src_b   = 2'd3;
          bus.alu_control = alu_ctrl;
          bus.illegal_op  = id_illegal;
        end
        S_EX: begin
          bus.alu_control = alu_ctrl;
          case (cls_q)
            CLS_LW, CLS_SW, CLS_ADDI: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd2;
            end
            CLS_RTYPE: bus.alu_src_a = 1'b1;
            CLS_BEQ: begin
              bus.alu_src_a = 1'b1;
              bus.pc_src    = 2'd1;
              bus.pc_en     = bus.zero;
            end
            CLS_J: begin
              bus.pc_src = 2'd2;
              bus.pc_en  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MA: begin
          bus.iord        = 1'b1;
          bus.mem_write   = (cls_q == CLS_SW);
          bus.alu_control = alu_ctrl;
        end
        S_WB: begin
          bus.reg_write   = 1'b1;
          bus.reg_dst     = (cls_q == CLS_RTYPE);
          bus.mem_to_reg  = (cls_q == CLS_LW);
          bus.alu_control = alu_ctrl;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_mips_mc_control_unit.sv
module tb_mips_mc_control_unit;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_unit_if #(.CNT_W(CNT_W)) bif ();

  mips_mc_control_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal_op;
  } ctl_t;

  typedef enum {
    P_FETCH, P_DECODE, P_DECODE_ILL, P_EX_ADDR, P_EX_RALU, P_EX_BR, P_EX_JMP,
    P_MA_LOAD, P_MA_STORE, P_WB_LOAD, P_WB_RTYPE, P_WB_ADDI
  } phase_t;

  typedef struct {
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  phase_t           seq[$];
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  int               n_issued = 0;
  bit               done = 1'b0;
  bit               drained = 1'b0;

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // What the datapath must see during each phase of an instruction.
  function automatic ctl_t expect_ctl(input phase_t p, input logic [5:0] fn, input logic z);
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    case (p)
      P_FETCH:      begin c.state = 3'd0; c.ir_write = 1'b1; c.alu_src_b = 2'd1; c.pc_en = 1'b1; end
      P_DECODE:     begin c.state = 3'd1; c.alu_src_b = 2'd3; end
      P_DECODE_ILL: begin c.state = 3'd1; c.alu_src_b = 2'd3; c.illegal_op = 1'b1; end
      P_EX_ADDR:    begin c.state = 3'd2; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      P_EX_RALU:    begin c.state = 3'd2; c.alu_src_a = 1'b1; c.alu_control = alu_of(fn); end
      P_EX_BR:      begin c.state = 3'd2; c.alu_src_a = 1'b1; c.alu_control = 3'b110;
                          c.pc_src = 2'd1; c.pc_en = z; end
      P_EX_JMP:     begin c.state = 3'd2; c.pc_src = 2'd2; c.pc_en = 1'b1; end
      P_MA_LOAD:    begin c.state = 3'd3; c.iord = 1'b1; end
      P_MA_STORE:   begin c.state = 3'd3; c.iord = 1'b1; c.mem_write = 1'b1; end
      P_WB_LOAD:    begin c.state = 3'd4; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      P_WB_RTYPE:   begin c.state = 3'd4; c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      P_WB_ADDI:    begin c.state = 3'd4; c.reg_write = 1'b1; end
      default:      ;
    endcase
    return c;
  endfunction

  // Phase list of one instruction; returns 1 when it is a legal (retiring) one.
  function automatic bit build_seq(input logic [5:0] op, input logic [5:0] fn);
    bit legal;
    legal = 1'b1;
    seq.delete();
    seq.push_back(P_FETCH);
    case (op)
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          seq.push_back(P_DECODE); seq.push_back(P_EX_RALU); seq.push_back(P_WB_RTYPE);
        end else legal = 1'b0;
      end
      6'h23: begin seq.push_back(P_DECODE); seq.push_back(P_EX_ADDR);
                   seq.push_back(P_MA_LOAD); seq.push_back(P_WB_LOAD); end
      6'h2B: begin seq.push_back(P_DECODE); seq.push_back(P_EX_ADDR); seq.push_back(P_MA_STORE); end
      6'h04: begin seq.push_back(P_DECODE); seq.push_back(P_EX_BR); end
      6'h08: begin seq.push_back(P_DECODE); seq.push_back(P_EX_ADDR); seq.push_back(P_WB_ADDI); end
      6'h02: begin seq.push_back(P_DECODE); seq.push_back(P_EX_JMP); end
      default: legal = 1'b0;
    endcase
    if (!legal) seq.push_back(P_DECODE_ILL);
    return legal;
  endfunction

  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      bif.opcode = 6'($urandom);
      bif.funct  = 6'($urandom);
      bif.zero   = 1'($urandom);
      e.ctl = '0;
      e.cnt = '0;
      e.tag = $sformatf("reset_%0d", i);
      sb.push_back(e);
    end
    cnt_m = '0;
  endtask

  // abort_at: phase index at which reset is pulsed (-1 = run to completion).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int abort_at);
    bit   legal;
    bit   aborted;
    exp_t e;
    legal   = build_seq(op, fn);
    aborted = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      reset      = 1'b0;
      bif.opcode = (i == 0) ? 6'($urandom) : op;
      bif.funct  = (i == 0) ? 6'($urandom) : fn;
      bif.zero   = (seq[i] == P_EX_BR) ? z : 1'($urandom);
      e.cnt = cnt_m;
      e.tag = $sformatf("i%0d_op%02h_fn%02h_%s", n_issued, op, fn, seq[i].name());
      if (i == abort_at) begin
        reset = 1'b1;
        e.ctl = '0;
        e.ctl.state = expect_ctl(seq[i], fn, z).state;
        e.tag = {e.tag, "_rst"};
        sb.push_back(e);
        cnt_m   = '0;
        aborted = 1'b1;
        break;
      end
      e.ctl = expect_ctl(seq[i], fn, z);
      sb.push_back(e);
    end
    if (!aborted && legal) cnt_m = cnt_m + CNT_W'(1);
    n_issued++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    ctl_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.state       = bif.state;
      a.pc_en       = bif.pc_en;
      a.pc_src      = bif.pc_src;
      a.iord        = bif.iord;
      a.mem_write   = bif.mem_write;
      a.ir_write    = bif.ir_write;
      a.reg_dst     = bif.reg_dst;
      a.mem_to_reg  = bif.mem_to_reg;
      a.reg_write   = bif.reg_write;
      a.alu_src_a   = bif.alu_src_a;
      a.alu_src_b   = bif.alu_src_b;
      a.alu_control = bif.alu_control;
      a.illegal_op  = bif.illegal_op;
      checks++;
      if (a !== e.ctl || bif.instr_count !== e.cnt) begin
        failures++;
        $display("FAIL %s: got ctl=%05h cnt=%0d, want ctl=%05h cnt=%0d",
                 e.tag, a, bif.instr_count, e.ctl, e.cnt);
      end
    end else if (done && !drained) begin
      checks++;
      drained = 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [5:0] legal_op [6];
    logic [5:0] legal_fn [5];
    logic [5:0] op, fn;
    int         ab;
    legal_op = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bif.opcode = '0;
    bif.funct  = '0;
    bif.zero   = 1'b0;

    do_reset(2);
    issue(6'h00, 6'h20, 1'b0, -1);
    issue(6'h23, 6'h11, 1'b0, -1);
    issue(6'h2B, 6'h05, 1'b1, -1);
    issue(6'h04, 6'h00, 1'b1, -1);
    issue(6'h04, 6'h00, 1'b0, -1);
    issue(6'h3F, 6'h20, 1'b0, -1);
    issue(6'h00, 6'h21, 1'b0, -1);
    issue(6'h08, 6'h3F, 1'b0, -1);
    issue(6'h02, 6'h00, 1'b1, -1);
    issue(6'h00, 6'h22, 1'b0, -1);
    issue(6'h00, 6'h24, 1'b0, -1);
    issue(6'h00, 6'h25, 1'b0, -1);
    issue(6'h00, 6'h2A, 1'b0, -1);
    issue(6'h2B, 6'h00, 1'b0, 3);
    issue(6'h00, 6'h20, 1'b0, -1);

    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_op[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      issue(op, fn, 1'($urandom), ab);
    end

    @(posedge clk); #1;
    done = 1'b1;
    for (int w = 0; w < 50 && !drained; w++) @(posedge clk);
    #6;
    if (!drained) begin
      $display("FAIL drain: scoreboard still holds %0d entries, want 0", sb.size());
      $fatal(1, "drain");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
